// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, split I/D cache-miss freezes,
// branch flushes, repeat-request gating and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           IF_ID_rs1_i,
    input  logic [4:0]           IF_ID_rs2_i,
    input  logic                 IF_ID_uses_rs1_i,
    input  logic                 IF_ID_uses_rs2_i,
    input  logic [4:0]           ID_EX_rd_i,
    input  logic                 ID_EX_mem_read_i,
    input  logic                 branch_taken_i,
    input  logic                 imem_read_i,
    input  logic                 imem_resp_i,
    input  logic                 dmem_read_i,
    input  logic                 dmem_write_i,
    input  logic                 dmem_resp_i,
    output logic                 imem_read_o,
    output logic                 dmem_read_o,
    output logic                 dmem_write_o,
    output logic                 pc_load_o,
    output logic                 IF_ID_load_o,
    output logic                 IF_ID_flush_o,
    output logic                 ID_EX_load_o,
    output logic                 ID_EX_bubble_o,
    output logic                 EX_MEM_load_o,
    output logic                 MEM_WB_load_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic                   imem_done_q, imem_done_d;
    logic                   dmem_done_q, dmem_done_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic imem_seen_s, dmem_seen_s;
    logic i_ready_s, d_ready_s, advance_s, load_use_s, cnt_inc_s;

    // Readiness, hazard detection and request gating.
    always_comb begin
        // A resp-seen latch can only be set after a non-advancing cycle, i.e. in WAIT.
        imem_seen_s = imem_done_q & (state_q == ST_WAIT);
        dmem_seen_s = dmem_done_q & (state_q == ST_WAIT);
        i_ready_s   = ~imem_read_i | imem_resp_i | imem_seen_s;
        d_ready_s   = ~(dmem_read_i | dmem_write_i) | dmem_resp_i | dmem_seen_s;
        advance_s   = i_ready_s & d_ready_s & ~rst;
        load_use_s  = ID_EX_mem_read_i & (ID_EX_rd_i != 5'd0) &
                      ((IF_ID_uses_rs1_i & (ID_EX_rd_i == IF_ID_rs1_i)) |
                       (IF_ID_uses_rs2_i & (ID_EX_rd_i == IF_ID_rs2_i)));
        cnt_inc_s   = ~advance_s | (load_use_s & ~branch_taken_i);
        imem_read_o  = imem_read_i  & ~imem_seen_s & ~rst;
        dmem_read_o  = dmem_read_i  & ~dmem_seen_s & ~rst;
        dmem_write_o = dmem_write_i & ~dmem_seen_s & ~rst;
    end

    // Stage enables: freeze beats branch flush beats load-use bubble.
    always_comb begin
        pc_load_o      = 1'b0;
        IF_ID_load_o   = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_load_o   = 1'b0;
        ID_EX_bubble_o = 1'b0;
        EX_MEM_load_o  = 1'b0;
        MEM_WB_load_o  = 1'b0;
        if (!advance_s) begin
            pc_load_o = 1'b0;
        end else if (branch_taken_i) begin
            pc_load_o      = 1'b1;
            IF_ID_load_o   = 1'b1;
            IF_ID_flush_o  = 1'b1;
            ID_EX_load_o   = 1'b1;
            ID_EX_bubble_o = 1'b1;
            EX_MEM_load_o  = 1'b1;
            MEM_WB_load_o  = 1'b1;
        end else if (load_use_s) begin
            ID_EX_load_o   = 1'b1;
            ID_EX_bubble_o = 1'b1;
            EX_MEM_load_o  = 1'b1;
            MEM_WB_load_o  = 1'b1;
        end else begin
            pc_load_o      = 1'b1;
            IF_ID_load_o   = 1'b1;
            ID_EX_load_o   = 1'b1;
            EX_MEM_load_o  = 1'b1;
            MEM_WB_load_o  = 1'b1;
        end
    end

    // Next state for resp-seen latches, FSM and stall counter.
    always_comb begin
        imem_done_d = imem_done_q;
        dmem_done_d = dmem_done_q;
        cnt_d       = cnt_q;
        if (advance_s) begin
            imem_done_d = 1'b0;
            dmem_done_d = 1'b0;
        end else begin
            imem_done_d = imem_done_q | imem_resp_i;
            dmem_done_d = dmem_done_q | dmem_resp_i;
        end
        if (cnt_inc_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        case (advance_s)
            1'b1:    state_d = ST_RUN;
            1'b0:    state_d = ST_WAIT;
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
            cnt_q       <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios then randomized traffic
// against a cycle-level reference model of the stall/flush rules.
module tb_hazard_stall_ctrl;

    localparam int     CW   = 6;
    localparam longint CMAX = (64'd1 << CW) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, ldr, br, ir, iresp, dr, dw, dresp;
    logic          imem_read_o, dmem_read_o, dmem_write_o;
    logic          pc_load_o, IF_ID_load_o, IF_ID_flush_o, ID_EX_load_o;
    logic          ID_EX_bubble_o, EX_MEM_load_o, MEM_WB_load_o;
    logic [CW-1:0] stall_cycles_o;

    hazard_stall_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2),
        .IF_ID_uses_rs1_i(u1), .IF_ID_uses_rs2_i(u2),
        .ID_EX_rd_i(rd), .ID_EX_mem_read_i(ldr), .branch_taken_i(br),
        .imem_read_i(ir), .imem_resp_i(iresp),
        .dmem_read_i(dr), .dmem_write_i(dw), .dmem_resp_i(dresp),
        .imem_read_o(imem_read_o), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .pc_load_o(pc_load_o), .IF_ID_load_o(IF_ID_load_o), .IF_ID_flush_o(IF_ID_flush_o),
        .ID_EX_load_o(ID_EX_load_o), .ID_EX_bubble_o(ID_EX_bubble_o),
        .EX_MEM_load_o(EX_MEM_load_o), .MEM_WB_load_o(MEM_WB_load_o),
        .stall_cycles_o(stall_cycles_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: has each cache already answered while stalled, stall count.
    bit     m_idone, m_ddone;
    longint m_cnt;
    bit     e_adv, e_lu;
    logic [6:0] e_en;   // {pc, IF_ID load, flush, ID_EX load, bubble, EX_MEM, MEM_WB}
    logic [2:0] e_req;  // {imem_read, dmem_read, dmem_write}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic predict();
        bit i_rdy, d_rdy;
        i_rdy = !ir || iresp || m_idone;
        d_rdy = !(dr || dw) || dresp || m_ddone;
        e_adv = i_rdy && d_rdy && !rst;
        e_lu  = ldr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        e_req = {ir && !m_idone && !rst, dr && !m_ddone && !rst, dw && !m_ddone && !rst};
        if (!e_adv)     e_en = 7'b0000000;
        else if (br)    e_en = 7'b1111111;
        else if (e_lu)  e_en = 7'b0001111;
        else            e_en = 7'b1101011;
    endtask

    task automatic update();
        if (rst) begin
            m_idone = 1'b0; m_ddone = 1'b0; m_cnt = 0;
        end else begin
            if (e_adv) begin
                m_idone = 1'b0; m_ddone = 1'b0;
            end else begin
                m_idone = m_idone || iresp;
                m_ddone = m_ddone || dresp;
            end
            if ((!e_adv || (e_lu && !br)) && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    endtask

    // Inputs already driven (just after a posedge): check comb outputs, clock once.
    task automatic cycle();
        #1;
        predict();
        check("enables", {57'd0, pc_load_o, IF_ID_load_o, IF_ID_flush_o, ID_EX_load_o,
                          ID_EX_bubble_o, EX_MEM_load_o, MEM_WB_load_o}, {57'd0, e_en});
        check("mem_req", {61'd0, imem_read_o, dmem_read_o, dmem_write_o}, {61'd0, e_req});
        check("stall_cycles", {{(64-CW){1'b0}}, stall_cycles_o}, m_cnt);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0;
        ldr = 1'b0; br = 1'b0; ir = 1'b0; iresp = 1'b0; dr = 1'b0; dw = 1'b0; dresp = 1'b0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    longint saved;

    initial begin
        m_idone = 1'b0; m_ddone = 1'b0; m_cnt = 0;
        idle(); rst = 1'b1;
        @(posedge clk); #1;
        do_reset();
        check("reset_count", {{(64-CW){1'b0}}, stall_cycles_o}, 64'd0);

        // 1: fetch hits every cycle, no hazards
        ir = 1'b1; iresp = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("t1_count", {{(64-CW){1'b0}}, stall_cycles_o}, 64'd0);

        // 2: lw x5 in EX, add x6,x5,x1 in ID -> one bubble
        ldr = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; u1 = 1'b1; u2 = 1'b1;
        cycle();
        ldr = 1'b0;
        cycle();
        check("t2_count", {{(64-CW){1'b0}}, stall_cycles_o}, 64'd1);

        // 3: x0 never hazards; unused rs2 never hazards
        ldr = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; cycle();
        rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5; u1 = 1'b1; u2 = 1'b0; cycle();
        check("t3_count", {{(64-CW){1'b0}}, stall_cycles_o}, 64'd1);

        // 4: imem resp cycle 2, dmem resp cycle 5
        do_reset();
        for (int c = 0; c < 6; c++) begin
            ir = 1'b1; dr = 1'b1; iresp = (c == 2); dresp = (c == 5);
            cycle();
        end
        idle();
        check("t4_count", {{(64-CW){1'b0}}, stall_cycles_o}, 64'd5);

        // 5: branch wins over load-use, counter unchanged
        saved = m_cnt;
        ir = 1'b1; iresp = 1'b1; br = 1'b1; ldr = 1'b1; rd = 5'd7; rs1 = 5'd7; u1 = 1'b1;
        cycle();
        idle();
        check("t5_count", {{(64-CW){1'b0}}, stall_cycles_o}, saved);

        // 6: reset in WAIT after imem resp drops the latch
        ir = 1'b1; dr = 1'b1; iresp = 1'b1; cycle();
        iresp = 1'b0; cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; #1;
        check("t6_imem_reassert", {63'd0, imem_read_o}, 64'd1);
        check("t6_count", {{(64-CW){1'b0}}, stall_cycles_o}, 64'd0);
        #1; cycle();

        // Saturation: hold an unanswered fetch well past the counter limit
        idle(); ir = 1'b1;
        for (int i = 0; i < 70; i++) cycle();
        check("sat_count", {{(64-CW){1'b0}}, stall_cycles_o}, CMAX);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            u1    = 1'($urandom_range(0, 1));
            u2    = 1'($urandom_range(0, 1));
            ldr   = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 5) == 0);
            ir    = ($urandom_range(0, 3) != 0);
            iresp = ($urandom_range(0, 2) == 0);
            dr    = ($urandom_range(0, 3) == 0);
            dw    = ($urandom_range(0, 4) == 0);
            dresp = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
